alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Execute-stage front end that drives the ALU. Decodes instruction fields into
//  ALUcontrol and operands (A,B), holds them registered at the ALU inputs for
//  one cycle, then captures ALU_result/zero with branch-taken and illegal flags.
//  Two-stage valid/ready pipeline between the decode/regfile logic and writeback.
// PARAMETERS
//  DATA_WIDTH        32  operand/result width
//  ALUCONTROL_WIDTH  4   width of ALU opcode
//  SHAMT_WIDTH       5   shift-amount bits kept in B for shifts ($clog2(DATA_WIDTH))
// PORTS
//  clk          in   1    clock, all flops rising edge
//  rst          in   1    asynchronous reset, active-high
//  in_valid     in   1    instruction fields valid
//  in_ready     out  1    stage 1 can accept
//  opcode       in   7    RV32 opcode
//  funct3       in   3    RV32 funct3
//  funct7_5     in   1    instr[30]
//  rs1_data     in   DW   source 1
//  rs2_data     in   DW   source 2
//  imm          in   DW   sign-extended immediate
//  alu_a        out  DW   to ALU A (registered)
//  alu_b        out  DW   to ALU B (registered)
//  alu_control  out  4    to ALUcontrol (registered)
//  alu_result   in   DW   from ALU_result (combinational)
//  alu_zero     in   1    from ALU zero
//  out_valid    out  1    result valid
//  out_ready    in   1    downstream accepts
//  out_result   out  DW   captured ALU result
//  out_branch_taken out 1 branch decision
//  out_illegal  out  1    unsupported encoding
// BEHAVIOUR
//  Codes: ADD 0000 SUB 0001 AND 0010 OR 0011 XOR 0100 SLT 0101 SHL 0110
//   SHR 0111 EQUAL 1001 NOT_EQUAL 1010.
//  Reset: s1_valid=0, out_valid=0, alu_a=alu_b=0, alu_control=ADD, out_result=0,
//   out_branch_taken=0, out_illegal=0. Reset mid-operation discards in-flight ops.
//  Handshake: s1_adv = !out_valid | out_ready; in_ready = !s1_valid | s1_adv.
//   Accept on in_valid&in_ready -> stage 1 loads; s1_valid&s1_adv -> stage 2
//   captures alu_result/zero, out_valid=1. Latency in->out 2 cycles, throughput 1/cycle.
//   Stall: out_valid&!out_ready holds all stage-2 outputs and, if s1_valid, stage 1
//   (ALU inputs stable). Stage 1 empty: alu_* hold last value.
//  Decode (stage 1 load):
//   0110011 R: f3 000 ADD(f7_5=0)/SUB(1); 111 AND; 110 OR; 100 XOR; 010 SLT;
//    001 SHL; 101 SHR (f7_5=1 SRA -> illegal); 011 illegal. B=rs2.
//   0010011 I: same map, B=imm, f3 000 always ADD; 101&f7_5=1 illegal.
//   1100011 BR: 000 BEQ SUB taken=zero; 001 BNE SUB taken=!zero;
//    100 BLT SLT taken=result[0]; others illegal. B=rs2.
//   0000011/0100011 LD/ST: ADD, B=imm (address).
//   other opcodes: illegal.
//  Shifts: alu_b = zero-extended low SHAMT_WIDTH bits of B.
//  Illegal: alu_control=ADD, alu_a=alu_b=0, out_result=0, out_illegal=1, taken=0.
//  out_branch_taken=0 for non-branch ops. SLT signedness is the ALU's.
// STRUCTURE
//  alu_pkg: ALU code localparams, opcode/funct3 constants, branch-kind encoding.
//  Sub-module alu_op_decoder: combinational fields -> {alu_control, b_sel,
//   is_shift, br_kind, illegal}; top holds both pipeline stages and handshake.
// TESTING
//  1 R ADD rs1=5 rs2=7 -> alu_control=0000, out_result=12 two cycles after accept.
//  2 BEQ rs1=rs2=9 -> SUB, taken=1; BNE same -> taken=0; BLT 3,4 -> taken=1.
//  3 SLLI imm=0x23 rs1=1 -> alu_b=3, out_result=8; SRA f7_5=1 -> illegal, result 0.
//  4 Back-to-back 4 ops, out_ready=0 for 3 cycles: in_ready drops once both stages
//    full, alu_* stable, no loss/duplication, order preserved on release.
//  5 opcode 1110011 -> out_illegal=1, taken=0, out_result=0.
//  6 rst asserted with both stages valid -> outputs return to reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, RV32 field constants and branch-kind encoding for the
// execute-stage issue controller.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SHL = 4'b0110;
  localparam logic [3:0] ALU_SHR = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1001;
  localparam logic [3:0] ALU_NE  = 4'b1010;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;

  typedef enum logic [1:0] {BR_NONE = 2'd0, BR_EQ = 2'd1, BR_NE = 2'd2, BR_LT = 2'd3} br_kind_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction-field decode into ALU opcode, B-source select,
// shift flag, branch kind and illegal flag.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control,
  output logic       b_sel,
  output logic       is_shift,
  output logic [1:0] br_kind,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    b_sel       = 1'b0;
    is_shift    = 1'b0;
    br_kind     = BR_NONE;
    illegal     = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        b_sel = (opcode == OP_I);
        case (funct3)
          F3_ADD: alu_control = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_AND: alu_control = ALU_AND;
          F3_OR:  alu_control = ALU_OR;
          F3_XOR: alu_control = ALU_XOR;
          F3_SLT: alu_control = ALU_SLT;
          F3_SLL: begin
            alu_control = ALU_SHL;
            is_shift    = 1'b1;
          end
          // arithmetic right shift is not supported by the ALU
          F3_SR: begin
            if (funct7_5) illegal = 1'b1;
            else begin
              alu_control = ALU_SHR;
              is_shift    = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_BR: begin
        case (funct3)
          F3_BEQ: begin alu_control = ALU_SUB; br_kind = BR_EQ; end
          F3_BNE: begin alu_control = ALU_SUB; br_kind = BR_NE; end
          F3_BLT: begin alu_control = ALU_SLT; br_kind = BR_LT; end
          default: illegal = 1'b1;
        endcase
      end
      OP_LD, OP_ST: b_sel = 1'b1;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage execute front end: stage 1 registers ALU inputs, stage 2 captures
// the ALU result with branch-taken and illegal flags behind a valid/ready handshake.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUCONTROL_WIDTH = 4,
  parameter int SHAMT_WIDTH      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  opcode,
  input  logic [2:0]                  funct3,
  input  logic                        funct7_5,
  input  logic [DATA_WIDTH-1:0]       rs1_data,
  input  logic [DATA_WIDTH-1:0]       rs2_data,
  input  logic [DATA_WIDTH-1:0]       imm,
  output logic [DATA_WIDTH-1:0]       alu_a,
  output logic [DATA_WIDTH-1:0]       alu_b,
  output logic [ALUCONTROL_WIDTH-1:0] alu_control,
  input  logic [DATA_WIDTH-1:0]       alu_result,
  input  logic                        alu_zero,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_result,
  output logic                        out_branch_taken,
  output logic                        out_illegal
);

  logic [3:0]            dec_ctrl;
  logic                  dec_bsel, dec_shift, dec_ill;
  logic [1:0]            dec_br;
  logic                  s1_valid, s1_illegal, s1_adv, accept, taken_nxt;
  br_kind_t              s1_br;
  logic [DATA_WIDTH-1:0] b_mux, b_eff;

  alu_op_decoder u_dec (
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_control(dec_ctrl),
    .b_sel      (dec_bsel),
    .is_shift   (dec_shift),
    .br_kind    (dec_br),
    .illegal    (dec_ill)
  );

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  assign b_mux = dec_bsel ? imm : rs2_data;
  assign b_eff = dec_shift ? DATA_WIDTH'(b_mux[SHAMT_WIDTH-1:0]) : b_mux;

  // Stage 1: ALU inputs only change on accept, so they stay stable while stalled or empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_illegal  <= 1'b0;
      s1_br       <= BR_NONE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALUCONTROL_WIDTH'(ALU_ADD);
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_illegal <= dec_ill;
      if (dec_ill) begin
        s1_br       <= BR_NONE;
        alu_a       <= '0;
        alu_b       <= '0;
        alu_control <= ALUCONTROL_WIDTH'(ALU_ADD);
      end else begin
        s1_br       <= br_kind_t'(dec_br);
        alu_a       <= rs1_data;
        alu_b       <= b_eff;
        alu_control <= ALUCONTROL_WIDTH'(dec_ctrl);
      end
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    taken_nxt = 1'b0;
    case (s1_br)
      BR_EQ:   taken_nxt = alu_zero;
      BR_NE:   taken_nxt = !alu_zero;
      BR_LT:   taken_nxt = alu_result[0];
      default: taken_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result       <= s1_illegal ? '0 : alu_result;
        out_branch_taken <= s1_illegal ? 1'b0 : taken_nxt;
        out_illegal      <= s1_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboarded bench for alu_issue_ctrl with a behavioural ALU and an
// instruction-level reference model.
module tb_alu_issue_ctrl;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, BR = 7'b1100011;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;

  typedef struct {logic [31:0] res; logic taken; logic ill;} exp_t;

  logic        clk, rst, in_valid, in_ready, funct7_5, out_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, imm, alu_a, alu_b, alu_result, out_result;
  logic [3:0]  alu_control;
  logic        alu_zero, out_valid, out_branch_taken, out_illegal;

  int   nchk = 0, nfail = 0;
  bit   rnd_rdy = 0;
  exp_t q[$];

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Environment ALU
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0110: alu_result = alu_a << alu_b[4:0];
      4'b0111: alu_result = alu_a >> alu_b[4:0];
      4'b1001: alu_result = (alu_a == alu_b) ? 32'd1 : 32'd0;
      4'b1010: alu_result = (alu_a != alu_b) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  function automatic exp_t model(logic [6:0] op, logic [2:0] f3, logic f7,
                                 logic [31:0] a, logic [31:0] b2, logic [31:0] im);
    exp_t e;
    logic [31:0] b;
    logic lt;
    e.res = 0; e.taken = 0; e.ill = 0;
    b = (op == I) ? im : b2;
    lt = $signed(a) < $signed(b);
    if (op == R || op == I) begin
      case (f3)
        3'd0: e.res = (op == R && f7) ? a - b : a + b;
        3'd7: e.res = a & b;
        3'd6: e.res = a | b;
        3'd4: e.res = a ^ b;
        3'd2: e.res = {31'd0, lt};
        3'd1: e.res = a << b[4:0];
        3'd5: if (f7) e.ill = 1; else e.res = a >> b[4:0];
        default: e.ill = 1;
      endcase
    end else if (op == BR) begin
      case (f3)
        3'd0: begin e.res = a - b; e.taken = (a == b); end
        3'd1: begin e.res = a - b; e.taken = (a != b); end
        3'd4: begin e.res = {31'd0, lt}; e.taken = lt; end
        default: e.ill = 1;
      endcase
    end else if (op == LD || op == ST) e.res = a + im;
    else e.ill = 1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL unexpected_output: got result %h with nothing expected", out_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_branch_taken", {31'd0, out_branch_taken}, {31'd0, e.taken});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Returns at posedge+1 just after the accepting edge
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    bit ok = 0;
    opcode = op; funct3 = f3; funct7_5 = f7; rs1_data = a; rs2_data = b; imm = im;
    in_valid = 1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(op, f3, f7, a, b, im));
        ok = 1;
      end
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    rnd_rdy = 0; out_ready = 1;
    for (int k = 0; k < 50 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    logic [31:0] sa, sb, sc;
    rst = 1; in_valid = 0; out_ready = 1; opcode = 0; funct3 = 0; funct7_5 = 0;
    rs1_data = 0; rs2_data = 0; imm = 0;
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_control", {28'd0, alu_control}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1; rst = 0;

    // R ADD latency
    send(R, 3'd0, 0, 5, 7, 0);
    chk("add_alu_control", {28'd0, alu_control}, 0);
    chk("add_out_valid_s1", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    chk("add_out_valid", {31'd0, out_valid}, 1);
    chk("add_out_result", out_result, 12);

    // branches
    send(BR, 3'd0, 0, 9, 9, 0);
    chk("beq_alu_control", {28'd0, alu_control}, 1);
    send(BR, 3'd1, 0, 9, 9, 0);
    send(BR, 3'd4, 0, 3, 4, 0);
    chk("blt_alu_control", {28'd0, alu_control}, 5);

    // shifts
    send(I, 3'd1, 0, 1, 0, 32'h23);
    chk("slli_alu_b", alu_b, 3);
    send(I, 3'd5, 1, 32'h8000_0000, 0, 32'h401);
    chk("srai_alu_b", alu_b, 0);
    chk("srai_alu_control", {28'd0, alu_control}, 0);

    // unsupported opcode
    send(7'b1110011, 3'd0, 0, 32'h55, 32'h66, 32'h77);
    chk("illegal_alu_a", alu_a, 0);
    drain();

    // stall with both stages full
    out_ready = 0;
    send(R, 3'd0, 0, 1, 2, 0);
    send(R, 3'd4, 0, 32'hF0F0, 32'h0FF0, 0);
    @(negedge clk);
    chk("stall_in_ready", {31'd0, in_ready}, 0);
    sa = alu_a; sb = alu_b; sc = {28'd0, alu_control};
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_alu_a", alu_a, sa);
    chk("stall_alu_b", alu_b, sb);
    chk("stall_alu_control", {28'd0, alu_control}, sc);
    chk("stall_out_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    out_ready = 1;
    send(R, 3'd7, 0, 32'hFF00, 32'h0FF0, 0);
    send(I, 3'd2, 0, 32'hFFFF_FFFF, 0, 1);
    drain();

    // random traffic with random backpressure
    rnd_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
        0: op = R; 1: op = I; 2: op = BR; 3: op = LD; 4: op = ST;
        default: op = 7'($urandom);
      endcase
      a = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15);
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15));
      send(op, 3'($urandom), 1'($urandom), a, b, $urandom);
    end
    drain();

    // reset with both stages occupied
    out_ready = 0;
    send(R, 3'd0, 0, 5, 7, 0);
    send(R, 3'd6, 0, 32'h10, 32'h01, 0);
    rst = 1; #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    q.delete();
    @(posedge clk); #1; rst = 0; out_ready = 1;
    send(LD, 3'd2, 0, 32'h100, 0, 32'h20);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
